i2cs_apb_reg_fifo: RTL and testbench
====================================

// Module: i2cs_apb_reg_fifo
// PURPOSE
//  Register/FIFO stage of the APB I2C slave. Sits directly downstream of the APB slave interface.
//  Consumes its registered write strobe/addr/data, combinational read address and read-complete pulse.
//  Returns read data to it. Buffers bytes between APB and the I2C slave engine in two sync FIFOs:
//  TX (APB->I2C) and RX (I2C->APB). Drives one level interrupt.
// PARAMETERS
//  FIFO_DEPTH  8   entries per FIFO; power of two, 2..256
//  DATA_W      8   FIFO entry width (bits)
//  ADDR_W      12  register address width
// PORTS
//  apb_pclk_i                 in   1         single clock, rising edge
//  apb_presetn_i              in   1         asynchronous active-low reset
//  apb_reg_waddr_i            in   ADDR_W    write address, registered upstream
//  apb_reg_wdata_i            in   32        write data, registered upstream
//  apb_reg_wrenable_i         in   1         1-cycle write strobe
//  apb_reg_raddr_i            in   ADDR_W    read address, combinational from PADDR
//  apb_reg_rdata_o            out  32        read data, combinational on raddr
//  apb_reg_rd_byte_complete_i in   1         1-cycle pulse, cycle after read access phase
//  i2c_rx_push_i/i2c_rx_data_i in  1/DATA_W  byte received from I2C master
//  i2c_tx_pop_i               in   1         I2C engine consumes TX head
//  i2c_tx_data_o/i2c_tx_valid_o out DATA_W/1 TX head; valid = TX not empty
//  irq_o                      out  1         |(IRQ_STATUS & IRQ_EN), registered
// BEHAVIOUR
//  Reset: both FIFOs empty; all registers 0. Outputs: rdata=0, tx_valid=0, tx_data=0, irq=0.
//  Register map (word offsets):
//   0x000 CTRL        [0] FLUSH (W, self-clearing)
//   0x004 STATUS      RO  [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full
//   0x008 TX_DATA     W   push wdata[DATA_W-1:0]
//   0x00C RX_DATA     R   head byte, zero-extended; 0 if empty
//   0x010 LEVEL       RO  [8:0] tx_level, [24:16] rx_level
//   0x014 IRQ_EN      RW  [3:0]
//   0x018 IRQ_STATUS  W1C [0] tx_ovf, [1] rx_ovf, [2] rx_udf, [3] rx_not_empty (live, not W1C)
//  Unmapped address: read 0, write ignored.
//  Write: takes effect on the clock edge where wrenable=1; visible on rdata the next cycle.
//  RX pop: raddr registered every cycle into raddr_q.
//   Pop occurs when rd_byte_complete && raddr_q==0x00C (latency 1 after access phase).
//  Levels: counters $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
//  Push while full:
//   - no simultaneous pop -> data dropped, level unchanged, ovf flag set;
//   - simultaneous pop   -> push accepted, level unchanged.
//  Pop while empty: ignored; RX side sets rx_udf; TX side cannot occur (valid=0).
//   With a simultaneous push, the push is accepted.
//  Simultaneous push+pop, not empty/full: level unchanged, both pointers advance.
//  FLUSH: empties both FIFOs in the write cycle. It overrides any push/pop in that same cycle.
//   Sticky flags are not cleared.
//  W1C: a 1 clears the flag, except when a set event occurs in the same cycle -> set wins.
//  Reset assertion mid-transfer: immediate async clear of all state; no partial bytes retained.
// CONFIGURATION
//  I2CS_FIFO_WATERMARK_EN defined:
//   - adds 0x01C WMARK RW [7:0] tx_wm, [23:16] rx_wm (reset 0);
//   - IRQ_STATUS[4] = tx_level<=tx_wm, IRQ_STATUS[5] = rx_level>=rx_wm (live), enabled by IRQ_EN[5:4].
//  Not defined: 0x01C reads 0, writes ignored; IRQ_STATUS/IRQ_EN bits [5:4] read 0.
// TESTING
//  1 Reset: apb_presetn_i=0 -> rdata(0x004)=0x5, irq_o=0, tx_valid=0, LEVEL=0.
//  2 Write 0xA1,0xB2,0xC3 to 0x008; pulse i2c_tx_pop_i x3
//    -> tx_data 0xA1,0xB2,0xC3 in order; tx_valid drops after the 3rd pop.
//  3 Push 9 RX bytes (DEPTH 8) -> rx_level=8, IRQ_STATUS[1]=1.
//    Read 0x00C x8 returns first 8 bytes in order.
//    9th read returns 0 and sets IRQ_STATUS[2].
//  4 RX full, i2c_rx_push_i coincident with read pop -> level stays 8, no rx_ovf, new byte at tail.
//  5 IRQ_EN=0x8, push 1 RX byte -> irq_o=1 one cycle later.
//    Read 0x00C -> irq_o=0. Write 0x7 to 0x018 clears sticky flags.
//  6 Watermark build, rx_wm=4: push 4 RX bytes -> IRQ_STATUS[5]=1.
//    Write CTRL=1 -> both levels 0, bit clears.

Source files
------------

// File: rtl/i2cs_apb_reg_fifo_if.sv
// Register-side bus between the APB slave front end and the register/FIFO stage.
// Carries the registered write strobe/address/data, the combinational read
// address, the read-complete pulse and the returned read data.
interface i2cs_apb_reg_fifo_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              wrenable;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata;
  logic              rd_byte_complete;

  modport master (
    output waddr, wdata, wrenable, raddr, rd_byte_complete,
    input  rdata
  );

  modport slave (
    input  waddr, wdata, wrenable, raddr, rd_byte_complete,
    output rdata
  );
endinterface

// File: rtl/i2cs_apb_reg_fifo.sv
// Register/FIFO stage of the APB I2C slave.
// TX FIFO carries bytes APB->I2C, RX FIFO carries bytes I2C->APB; one level irq.
// Optional feature: define I2CS_FIFO_WATERMARK_EN to add the WMARK register
// (0x01C) and the two live watermark interrupt sources IRQ_STATUS[5:4].
module i2cs_apb_reg_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                 apb_pclk_i,
  input  logic                 apb_presetn_i,
  i2cs_apb_reg_fifo_if.slave   apb,
  input  logic                 i2c_rx_push_i,
  input  logic [DATA_W-1:0]    i2c_rx_data_i,
  input  logic                 i2c_tx_pop_i,
  output logic [DATA_W-1:0]    i2c_tx_data_o,
  output logic                 i2c_tx_valid_o,
  output logic                 irq_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'('h000);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'('h004);
  localparam logic [ADDR_W-1:0] A_TXD   = ADDR_W'('h008);
  localparam logic [ADDR_W-1:0] A_RXD   = ADDR_W'('h00C);
  localparam logic [ADDR_W-1:0] A_LEVEL = ADDR_W'('h010);
  localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'('h014);
  localparam logic [ADDR_W-1:0] A_IST   = ADDR_W'('h018);
`ifdef I2CS_FIFO_WATERMARK_EN
  localparam logic [ADDR_W-1:0] A_WMARK = ADDR_W'('h01C);
  localparam int IRQ_W = 6;
`else
  localparam int IRQ_W = 4;
`endif

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0]  tx_level, rx_level;
  logic [ADDR_W-1:0] raddr_q;
  logic [2:0]        flags;     // {rx_udf, rx_ovf, tx_ovf}
  logic [IRQ_W-1:0]  irq_en;
  logic [IRQ_W-1:0]  irq_status;
  logic              irq_q;
`ifdef I2CS_FIFO_WATERMARK_EN
  logic [7:0]        tx_wm, rx_wm;
`endif

  logic flush, tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic rx_pop_req, rx_push, rx_pop, rx_ovf_set, rx_udf_set;
  logic [2:0] w1c;

  assign flush    = apb.wrenable && (apb.waddr == A_CTRL) && apb.wdata[0];
  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == FULL_LVL);
  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == FULL_LVL);

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  assign tx_push_req = apb.wrenable && (apb.waddr == A_TXD);
  assign tx_pop      = i2c_tx_pop_i && !tx_empty && !flush;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop) && !flush;
  assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop && !flush;

  assign rx_pop_req  = apb.rd_byte_complete && (raddr_q == A_RXD);
  assign rx_pop      = rx_pop_req && !rx_empty && !flush;
  assign rx_push     = i2c_rx_push_i && (!rx_full || rx_pop) && !flush;
  assign rx_ovf_set  = i2c_rx_push_i && rx_full && !rx_pop && !flush;
  assign rx_udf_set  = rx_pop_req && rx_empty && !flush;

  assign w1c = (apb.wrenable && (apb.waddr == A_IST)) ? apb.wdata[2:0] : '0;

`ifdef I2CS_FIFO_WATERMARK_EN
  assign irq_status = {9'(rx_level) >= {1'b0, rx_wm},
                       9'(tx_level) <= {1'b0, tx_wm},
                       !rx_empty, flags};
`else
  assign irq_status = {!rx_empty, flags};
`endif

  assign i2c_tx_valid_o = !tx_empty;
  assign i2c_tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign irq_o          = irq_q;

  // TX FIFO pointers and level; flush empties it regardless of concurrent traffic.
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else if (flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_level <= tx_level + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end
  end

  // RX FIFO pointers and level.
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else if (flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_level <= rx_level + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  // FIFO storage; contents are only observable through the levels, so no reset is needed.
  always_ff @(posedge apb_pclk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= apb.wdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= i2c_rx_data_i;
  end

  // Control registers, sticky flags (set beats W1C clear), read address pipe and irq.
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      raddr_q <= '0;
      flags   <= '0;
      irq_en  <= '0;
      irq_q   <= 1'b0;
`ifdef I2CS_FIFO_WATERMARK_EN
      tx_wm   <= '0;
      rx_wm   <= '0;
`endif
    end else begin
      raddr_q <= apb.raddr;
      flags   <= {rx_udf_set, rx_ovf_set, tx_ovf_set} | (flags & ~w1c);
      irq_q   <= |(irq_status & irq_en);
      if (apb.wrenable && (apb.waddr == A_IEN)) irq_en <= apb.wdata[IRQ_W-1:0];
`ifdef I2CS_FIFO_WATERMARK_EN
      if (apb.wrenable && (apb.waddr == A_WMARK)) begin
        tx_wm <= apb.wdata[7:0];
        rx_wm <= apb.wdata[23:16];
      end
`endif
    end
  end

  // Combinational read mux on the live read address.
  always_comb begin
    apb.rdata = '0;
    case (apb.raddr)
      A_STAT:  apb.rdata = {28'd0, rx_full, rx_empty, tx_full, tx_empty};
      A_RXD:   apb.rdata = rx_empty ? '0 : 32'(rx_mem[rx_rd_ptr]);
      A_LEVEL: apb.rdata = 32'(tx_level) | (32'(rx_level) << 16);
      A_IEN:   apb.rdata = 32'(irq_en);
      A_IST:   apb.rdata = 32'(irq_status);
`ifdef I2CS_FIFO_WATERMARK_EN
      A_WMARK: apb.rdata = {8'd0, rx_wm, 8'd0, tx_wm};
`endif
      default: apb.rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_i2cs_apb_reg_fifo.sv
// Directed self-checking bench for i2cs_apb_reg_fifo (default depth 8).
module tb_i2cs_apb_reg_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_push = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_pop = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       irq;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [31:0] d;

  i2cs_apb_reg_fifo_if #(.ADDR_W(12)) bus ();

  i2cs_apb_reg_fifo #(.FIFO_DEPTH(8), .DATA_W(8), .ADDR_W(12)) dut (
    .apb_pclk_i     (clk),
    .apb_presetn_i  (rst_n),
    .apb            (bus),
    .i2c_rx_push_i  (rx_push),
    .i2c_rx_data_i  (rx_data),
    .i2c_tx_pop_i   (tx_pop),
    .i2c_tx_data_o  (tx_data),
    .i2c_tx_valid_o (tx_valid),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    bus.waddr = a; bus.wdata = v; bus.wrenable = 1'b1;
    @(posedge clk); #1;
    bus.wrenable = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus.raddr = a; #1;
    v = bus.rdata;
  endtask

  // Access phase on RX_DATA, then the read-complete pulse (optionally with a coincident RX push).
  task automatic rx_read(output logic [31:0] v, input logic push, input logic [7:0] pd);
    bus.raddr = 12'h00C; #1;
    v = bus.rdata;
    @(posedge clk); #1;
    bus.raddr = 12'h000;
    bus.rd_byte_complete = 1'b1;
    rx_push = push; rx_data = pd;
    @(posedge clk); #1;
    bus.rd_byte_complete = 1'b0;
    rx_push = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_push = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_push = 1'b0;
  endtask

  task automatic pop_tx();
    tx_pop = 1'b1;
    @(posedge clk); #1;
    tx_pop = 1'b0;
  endtask

  initial begin
    bus.waddr = '0; bus.wdata = '0; bus.wrenable = 1'b0;
    bus.raddr = '0; bus.rd_byte_complete = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rd(12'h004, d); check("rst_status", d, 32'h5);
    rd(12'h010, d); check("rst_level", d, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_txvalid", {31'd0, tx_valid}, 32'h0);
    check("rst_txdata", {24'd0, tx_data}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // TX ordering
    wr(12'h008, 32'hA1); wr(12'h008, 32'hB2); wr(12'h008, 32'hC3);
    rd(12'h010, d); check("tx_level3", d, 32'h3);
    check("tx_head0", {23'd0, tx_valid, tx_data}, 32'h1A1);
    pop_tx(); check("tx_head1", {23'd0, tx_valid, tx_data}, 32'h1B2);
    pop_tx(); check("tx_head2", {23'd0, tx_valid, tx_data}, 32'h1C3);
    pop_tx(); check("tx_drained", {23'd0, tx_valid, tx_data}, 32'h000);

    // TX overflow, then flush keeps sticky flag
    for (int unsigned i = 0; i < 9; i++) wr(12'h008, 32'h40 + i);
    rd(12'h010, d); check("tx_level_full", d, 32'h8);
    rd(12'h004, d); check("tx_full_status", d, 32'h6);
    rd(12'h018, d); check("tx_ovf", d, 32'h1);
    wr(12'h000, 32'h1);
    rd(12'h010, d); check("flush_level", d, 32'h0);
    rd(12'h004, d); check("flush_status", d, 32'h5);
    rd(12'h018, d); check("flush_keeps_flag", d, 32'h1);
    wr(12'h018, 32'h1);
    rd(12'h018, d); check("w1c_tx_ovf", d, 32'h0);

    // RX overflow and underflow
    for (int unsigned i = 0; i < 9; i++) push_rx(8'h10 + 8'(i));
    rd(12'h010, d); check("rx_level_full", d, 32'h0008_0000);
    rd(12'h004, d); check("rx_full_status", d, 32'h9);
    rd(12'h018, d); check("rx_ovf", d, 32'hA);
    for (int unsigned i = 0; i < 8; i++) begin
      rx_read(d, 1'b0, 8'h00);
      check($sformatf("rx_byte%0d", i), d, 32'h10 + i);
    end
    rx_read(d, 1'b0, 8'h00); check("rx_empty_read", d, 32'h0);
    rd(12'h018, d); check("rx_udf", d, 32'h6);
    wr(12'h018, 32'h7);
    rd(12'h018, d); check("w1c_all", d, 32'h0);

    // RX full with coincident push and pop, then set-beats-clear on rx_ovf
    for (int unsigned i = 0; i < 8; i++) push_rx(8'h20 + 8'(i));
    rx_read(d, 1'b1, 8'h99); check("rx_pushpop_head", d, 32'h20);
    rd(12'h010, d); check("rx_pushpop_level", d, 32'h0008_0000);
    rd(12'h018, d); check("rx_pushpop_no_ovf", d, 32'h8);
    rx_push = 1'b1; rx_data = 8'hEE;
    wr(12'h018, 32'h2);
    rx_push = 1'b0;
    rd(12'h018, d); check("set_beats_w1c", d, 32'hA);
    for (int unsigned i = 1; i < 8; i++) begin
      rx_read(d, 1'b0, 8'h00);
      check($sformatf("rx_drain%0d", i), d, 32'h20 + i);
    end
    rx_read(d, 1'b0, 8'h00); check("rx_tail_byte", d, 32'h99);
    rd(12'h004, d); check("rx_empty_status", d, 32'h5);
    wr(12'h018, 32'h7);

    // Interrupt on rx_not_empty
    wr(12'h014, 32'h8);
    rd(12'h014, d); check("irq_en_rb", d, 32'h8);
    check("irq_idle", {31'd0, irq}, 32'h0);
    push_rx(8'h55);
    check("irq_not_yet", {31'd0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_set", {31'd0, irq}, 32'h1);
    rx_read(d, 1'b0, 8'h00); check("irq_byte", d, 32'h55);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'h0);

    // Unmapped / optional register
    rd(12'h100, d); check("unmapped_rd", d, 32'h0);
`ifdef I2CS_FIFO_WATERMARK_EN
    wr(12'h01C, 32'h0004_0000);
    for (int unsigned i = 0; i < 4; i++) push_rx(8'h60 + 8'(i));
    rd(12'h018, d); check("wm_rx_set", d & 32'h20, 32'h20);
    wr(12'h000, 32'h1);
    rd(12'h010, d); check("wm_flush_level", d, 32'h0);
    rd(12'h018, d); check("wm_rx_clear", d & 32'h20, 32'h0);
`else
    wr(12'h01C, 32'hFFFF_FFFF);
    rd(12'h01C, d); check("wmark_absent", d, 32'h0);
`endif

    // Asynchronous reset mid-transfer
    push_rx(8'h77); wr(12'h008, 32'h12);
    bus.raddr = 12'h010;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", bus.rdata, 32'h0);
    check("async_rst_txvalid", {31'd0, tx_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
